// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan display.
//   SEG_BLANK / SEG_ZERO / SEG_MINUS : segment patterns, bit order {a,b,c,d,e,f,g}, 1 = lit
//   state_t                          : load/convert FSM state
//   nib2seg()                        : 4-bit digit -> segment pattern
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_ZERO  = 7'b1111110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPT,
        ST_CONV
    } state_t;

    function automatic logic [6:0] nib2seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Load channel of the seven-segment display driver.
//   load_valid  : new value offered (master -> slave)
//   load_ready  : driver idle, load accepted on valid & ready (slave -> master)
//   load_data   : value to display, DATA_W bits
//   load_signed : load_data is two's complement
//   load_hex    : 1 = hex digits, 0 = decimal digits
interface seg7_scan_display_if #(
    parameter int DATA_W = 32
);
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_signed;
    logic              load_hex;

    modport master (
        output load_valid, load_data, load_signed, load_hex,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_data, load_signed, load_hex,
        output load_ready
    );
endinterface

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble binary -> BCD converter.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle pulse; bin is sampled and the first shift step is done on this edge
//   bin      : unsigned value, DATA_W bits
//   done     : one-cycle pulse in the cycle after the last of DATA_W shift steps
//   bcd      : DIGITS BCD nibbles, valid while done is high (held afterwards)
//   ovf      : a 1 was shifted out of the top nibble (value >= 10^DIGITS)
module seg7_bin2bcd #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   bin,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   shreg;
    logic [CNT_W-1:0]    cnt;    // shift steps still to do
    logic [4*DIGITS-1:0] cur;
    logic [4*DIGITS-1:0] adj;
    logic                cur_bit;

    // The start edge performs step 1 directly from bin, so the whole
    // conversion takes exactly DATA_W edges starting with start.
    always_comb begin
        cur     = start ? '0 : bcd;
        cur_bit = start ? bin[DATA_W-1] : shreg[DATA_W-1];
        adj     = cur;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cur[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = cur[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg <= bin << 1;
                bcd   <= {adj[4*DIGITS-2:0], cur_bit};
                ovf   <= 1'b0;
                cnt   <= CNT_W'(DATA_W - 1);
                done  <= (DATA_W == 1);
            end else if (cnt != '0) begin
                shreg <= shreg << 1;
                bcd   <= {adj[4*DIGITS-2:0], cur_bit};
                ovf   <= ovf | adj[4*DIGITS-1];
                cnt   <= cnt - 1'b1;
                done  <= (cnt == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-digit seven-segment display driver: accepts a value over the load
// channel, converts it to decimal (double-dabble) or hex, and time-multiplexes
// DIGITS digits plus a sign indicator.
//   clk, rst : clock, synchronous active-high reset
//   load     : load channel (slave modport of seg7_scan_display_if)
//   busy     : conversion in progress (state != IDLE)
//   ovf      : last value needed more than DIGITS digits (low digits shown)
//   seg      : {a,b,c,d,e,f,g}, 1 = lit, for the digit selected by an
//   an       : one-hot digit enable, bit 0 = least significant digit
//   neg      : minus sign
// Build option: define SEG7_LZ_BLANK_EN to blank digits above the most
// significant nonzero digit (digit 0 is never blanked).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_display_if.slave load,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              neg
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HB    = (DATA_W < 4*DIGITS) ? DATA_W : 4*DIGITS;

    state_t              state;
    logic [DATA_W-1:0]   mag_q;
    logic                sign_q;
    logic                hex_q;
    logic [4*DIGITS-1:0] disp;

    logic                accept;
    logic                in_neg;
    logic [DATA_W-1:0]   mag_in;
    logic [4*DIGITS-1:0] hex_digits;
    logic                hex_ovf;
    logic                conv_start;
    logic                conv_done;
    logic                conv_ovf;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [4*DIGITS-1:0] disp_next;
    logic                neg_next;
    logic                ovf_next;

    logic [PRE_W-1:0]    pre;
    logic                pre_wrap;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic [DIGITS-1:0]   an_next;
    logic [3:0]          nib;
    logic [6:0]          seg_next;
`ifdef SEG7_LZ_BLANK_EN
    logic [IDX_W-1:0]    msd;
`endif

    assign busy            = (state != ST_IDLE);
    assign load.load_ready = ~busy & ~rst;
    assign accept          = load.load_valid & load.load_ready;
    assign conv_start      = (state == ST_CAPT) & ~hex_q;

    // Magnitude is formed at the accept edge and consumed in CAPT; the most
    // negative input naturally maps to 2^(DATA_W-1).
    assign in_neg = load.load_signed & load.load_data[DATA_W-1];
    assign mag_in = in_neg ? -load.load_data : load.load_data;

    always_comb begin
        hex_digits = '0;
        hex_ovf    = 1'b0;
        for (int unsigned b = 0; b < HB; b++) begin
            hex_digits[b] = mag_q[b];
        end
        for (int unsigned b = HB; b < DATA_W; b++) begin
            hex_ovf = hex_ovf | mag_q[b];
        end
    end

    seg7_bin2bcd #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (mag_q),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Next display contents; digits, sign and ovf always switch together.
    always_comb begin
        disp_next = disp;
        neg_next  = neg;
        ovf_next  = ovf;
        if ((state == ST_CAPT) && hex_q) begin
            disp_next = hex_digits;
            neg_next  = sign_q;
            ovf_next  = hex_ovf;
        end else if ((state == ST_CONV) && conv_done) begin
            disp_next = conv_bcd;
            neg_next  = sign_q;
            ovf_next  = conv_ovf;
        end
    end

    // seg is decoded from next-cycle digit index and display contents so the
    // registered seg/an pair tracks display updates without a cycle of lag.
    always_comb begin
        pre_wrap = (pre == PRE_W'(SCAN_DIV - 1));
        idx_next = idx;
        if (pre_wrap) begin
            idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
        an_next           = '0;
        an_next[idx_next] = 1'b1;
        nib               = disp_next[4*idx_next +: 4];
        seg_next          = nib2seg(nib);
`ifdef SEG7_LZ_BLANK_EN
        msd = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (disp_next[4*i +: 4] != 4'd0) begin
                msd = IDX_W'(i);
            end
        end
        if (idx_next > msd) begin
            seg_next = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mag_q  <= '0;
            sign_q <= 1'b0;
            hex_q  <= 1'b0;
            disp   <= '0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            pre    <= '0;
            idx    <= '0;
            an     <= DIGITS'(1);
            seg    <= SEG_ZERO;
        end else begin
            disp <= disp_next;
            neg  <= neg_next;
            ovf  <= ovf_next;
            pre  <= pre_wrap ? '0 : pre + 1'b1;
            idx  <= idx_next;
            an   <= an_next;
            seg  <= seg_next;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mag_q  <= mag_in;
                        sign_q <= in_neg & (mag_in != '0);
                        hex_q  <= load.load_hex;
                        state  <= ST_CAPT;
                    end
                end
                ST_CAPT: state <= hex_q ? ST_IDLE : ST_CONV;
                ST_CONV: if (conv_done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
